// File: rtl/mem_lsu_pkg.sv
// Shared RV32I types for the load/store unit: word type, load/store funct3 codes
// and the LSU sequencing state.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and the data memory (slave).
interface mem_lsu_if;
    import rv32i_types::*;

    rv32i_word   dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    rv32i_word   dmem_wdata;
    rv32i_word   dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_lsu_load_extend.sv
// Combinational load extraction: selects the byte/halfword addressed by bit_shift
// from the raw memory word and sign- or zero-extends it.
module load_extend
    import rv32i_types::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] bit_shift,
    input  rv32i_word  rdata,
    output rv32i_word  result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{bit_shift, 3'b000} +: 8];
        half_sel = bit_shift[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;
        case (load_funct3_t'(funct3))
            lb:      result = {{24{byte_sel[7]}}, byte_sel};
            lbu:     result = {24'h000000, byte_sel};
            lh:      result = {{16{half_sel[15]}}, half_sel};
            lhu:     result = {16'h0000, half_sel};
            lw:      result = rdata;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one data-memory access per load/store,
// stalls the pipeline until the response, then presents the extended result.
//
// state | meaning
// IDLE  | no access outstanding; a valid load/store launches one
// BUSY  | strobe held on the dmem bus, waiting for dmem_resp
// DONE  | result valid for one cycle; pipeline released
module mem_lsu
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic        trap_in,
    input  rv32i_word   addr_aligned,
    input  logic [1:0]  bit_shift,
    input  logic [3:0]  wmask_in,
    input  rv32i_word   write_data,
    mem_lsu_if.master   dmem,
    output logic        stall,
    output rv32i_word   load_data,
    output logic        done,
    output rv32i_word   mem_rdata_rvfi,
    output rv32i_word   mem_wdata_rvfi
);

    lsu_state_t state, next_state;

    logic       req;
    logic       read_q, write_q, is_store_q;
    logic [2:0] funct3_q;
    logic [1:0] bit_shift_q;
    logic [3:0] wmask_q;
    rv32i_word  address_q, wdata_q;
    rv32i_word  load_data_q, rdata_rvfi_q, wdata_rvfi_q;
    rv32i_word  extended;

    assign req = (mem_read | mem_write) & ~trap_in;

    load_extend u_load_extend (
        .funct3    (funct3_q),
        .bit_shift (bit_shift_q),
        .rdata     (dmem.dmem_rdata),
        .result    (extended)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    stall      = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem.dmem_resp) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Stores win over loads when both flags are set; loads never drive a byte mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            bit_shift_q  <= 2'b00;
            wmask_q      <= 4'b0000;
            address_q    <= '0;
            wdata_q      <= '0;
            load_data_q  <= '0;
            rdata_rvfi_q <= '0;
            wdata_rvfi_q <= '0;
        end else begin
            if (state == IDLE && req) begin
                read_q      <= mem_read & ~mem_write;
                write_q     <= mem_write;
                is_store_q  <= mem_write;
                funct3_q    <= funct3;
                bit_shift_q <= bit_shift;
                address_q   <= addr_aligned;
                wmask_q     <= mem_write ? wmask_in : 4'b0000;
                wdata_q     <= mem_write ? (write_data << {bit_shift, 3'b000}) : '0;
            end
            if (state == BUSY && dmem.dmem_resp) begin
                read_q       <= 1'b0;
                write_q      <= 1'b0;
                rdata_rvfi_q <= dmem.dmem_rdata;
                wdata_rvfi_q <= wdata_q;
                load_data_q  <= is_store_q ? '0 : extended;
            end
        end
    end

    assign dmem.dmem_read    = read_q;
    assign dmem.dmem_write   = write_q;
    assign dmem.dmem_address = address_q;
    assign dmem.dmem_wmask   = wmask_q;
    assign dmem.dmem_wdata   = wdata_q;

    assign done           = (state == DONE);
    assign load_data      = load_data_q;
    assign mem_rdata_rvfi = rdata_rvfi_q;
    assign mem_wdata_rvfi = wdata_rvfi_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios followed by randomized
// loads/stores against a word-array memory model and an arithmetic load reference.
module tb_mem_lsu;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, trap_in;
    logic [2:0]  funct3;
    logic [31:0] addr_aligned, write_data;
    logic [1:0]  bit_shift;
    logic [3:0]  wmask_in;
    logic        stall, done;
    logic [31:0] load_data, mem_rdata_rvfi, mem_wdata_rvfi;

    mem_lsu_if dmem_bus ();

    mem_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .trap_in        (trap_in),
        .addr_aligned   (addr_aligned),
        .bit_shift      (bit_shift),
        .wmask_in       (wmask_in),
        .write_data     (write_data),
        .dmem           (dmem_bus),
        .stall          (stall),
        .load_data      (load_data),
        .done           (done),
        .mem_rdata_rvfi (mem_rdata_rvfi),
        .mem_wdata_rvfi (mem_wdata_rvfi)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    bit          in_done = 1'b0;
    logic [31:0] last_ld = 32'h0;
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] mask_of(input int f3, input int bs);
        int sz;
        int m;
        sz = 1 << (f3 & 3);
        m  = ((1 << sz) - 1) << bs;
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input int bs, input logic [31:0] w);
        longint v;
        v = 0;
        case (f3)
            0: begin v = (w >> (8 * bs)) & 255;          if (v >= 128)   v = v - 256;   end
            1: begin v = (w >> (16 * (bs / 2))) & 65535; if (v >= 32768) v = v - 65536; end
            4: v = (w >> (8 * bs)) & 255;
            5: v = (w >> (16 * (bs / 2))) & 65535;
            default: v = w;
        endcase
        return v[31:0];
    endfunction

    // Presents one MEM-stage instruction and walks it to completion, checking every cycle.
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int lat, input bit trap);
        logic [3:0]  wm;
        logic [31:0] exp_wd, aw, word;
        bit          exp_rd;
        wm     = mask_of(f3, addr[1:0]);
        aw     = {addr[31:2], 2'b00};
        exp_wd = wd << (8 * addr[1:0]);
        exp_rd = ld & ~st;
        mem_read     = ld;
        mem_write    = st;
        funct3       = f3;
        trap_in      = trap;
        addr_aligned = aw;
        bit_shift    = addr[1:0];
        wmask_in     = wm;
        write_data   = wd;
        if (in_done) begin
            #1;
            chk("done_stall", {31'b0, stall}, 32'd0);
            chk("done_no_issue", {30'b0, dmem_bus.dmem_read, dmem_bus.dmem_write}, 32'd0);
            @(negedge clk);
        end
        in_done = 1'b0;
        #1;
        chk("idle_stall", {31'b0, stall}, {31'b0, ~trap});
        chk("idle_strobes", {30'b0, dmem_bus.dmem_read, dmem_bus.dmem_write}, 32'd0);
        chk("idle_done", {31'b0, done}, 32'd0);
        if (trap) begin
            @(negedge clk);
            #1;
            chk("trap_stall", {31'b0, stall}, 32'd0);
            chk("trap_strobes", {30'b0, dmem_bus.dmem_read, dmem_bus.dmem_write}, 32'd0);
            chk("trap_done", {31'b0, done}, 32'd0);
            return;
        end
        @(negedge clk);
        for (int k = 0; k <= lat; k++) begin
            #1;
            chk("busy_read", {31'b0, dmem_bus.dmem_read}, {31'b0, exp_rd});
            chk("busy_write", {31'b0, dmem_bus.dmem_write}, {31'b0, st});
            chk("busy_addr", dmem_bus.dmem_address, aw);
            chk("busy_wmask", {28'b0, dmem_bus.dmem_wmask}, st ? {28'b0, wm} : 32'd0);
            if (st) chk("busy_wdata", dmem_bus.dmem_wdata, exp_wd);
            chk("busy_stall", {31'b0, stall}, 32'd1);
            chk("busy_done", {31'b0, done}, 32'd0);
            if (k == lat) begin
                dmem_bus.dmem_rdata = rdat;
                dmem_bus.dmem_resp  = 1'b1;
            end
            @(negedge clk);
            dmem_bus.dmem_resp = 1'b0;
        end
        #1;
        last_ld = st ? 32'h0 : ref_load(f3, addr[1:0], rdat);
        chk("done_flag", {31'b0, done}, 32'd1);
        chk("done_stall0", {31'b0, stall}, 32'd0);
        chk("done_strobes", {30'b0, dmem_bus.dmem_read, dmem_bus.dmem_write}, 32'd0);
        chk("load_data", load_data, last_ld);
        chk("rvfi_rdata", mem_rdata_rvfi, rdat);
        if (st) begin
            chk("rvfi_wdata", mem_wdata_rvfi, exp_wd);
            word = mem.exists(aw) ? mem[aw] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (wm[b]) word[8*b +: 8] = exp_wd[8*b +: 8];
            mem[aw] = word;
        end
        in_done = 1'b1;
    endtask

    task automatic go_idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        trap_in   = 1'b0;
        @(negedge clk);
        in_done = 1'b0;
        #1;
        chk("load_hold", load_data, last_ld);
        chk("idle_nodone", {31'b0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        mem_read = 0; mem_write = 0; trap_in = 0; funct3 = 0;
        addr_aligned = 0; bit_shift = 0; wmask_in = 0; write_data = 0;
        dmem_bus.dmem_rdata = 0;
        dmem_bus.dmem_resp  = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_strobes", {30'b0, dmem_bus.dmem_read, dmem_bus.dmem_write}, 32'd0);
        chk("rst_addr", dmem_bus.dmem_address, 32'd0);
        chk("rst_wmask", {28'b0, dmem_bus.dmem_wmask}, 32'd0);
        chk("rst_wdata", dmem_bus.dmem_wdata, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_done_stall", {30'b0, done, stall}, 32'd0);
        chk("rst_rvfi", mem_rdata_rvfi | mem_wdata_rvfi, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // lb at 0x1003, response in the third BUSY cycle
        run_op(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 2, 0);
        go_idle();
        // sh at 0x2002
        run_op(0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h1234_5678, 3, 0);
        go_idle();
        // lhu at 0x3002
        run_op(1, 0, 3'b101, 32'h0000_3002, 32'h0, 32'h8001_0000, 1, 0);
        go_idle();
        // trapped load
        run_op(1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 0, 1);
        go_idle();

        // reset in BUSY, then the held request is reissued
        mem_read = 1; mem_write = 0; funct3 = 3'b010; trap_in = 0;
        addr_aligned = 32'h0000_4000; bit_shift = 2'b00; wmask_in = 4'hF; write_data = 0;
        #1;
        @(negedge clk);
        #1;
        chk("pre_rst_read", {31'b0, dmem_bus.dmem_read}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_read", {31'b0, dmem_bus.dmem_read}, 32'd0);
        chk("mid_rst_addr", dmem_bus.dmem_address, 32'd0);
        chk("mid_rst_load", load_data, 32'd0);
        chk("mid_rst_rvfi", mem_rdata_rvfi, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_ld = 32'h0;
        run_op(1, 0, 3'b010, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 1, 0);
        go_idle();

        // back-to-back lw then sw, same-cycle responses
        run_op(1, 0, 3'b010, 32'h0000_4004, 32'h0, 32'h0BAD_CAFE, 0, 0);
        run_op(0, 1, 3'b010, 32'h0000_4008, 32'h1357_9BDF, 32'h0, 0, 0);
        // both flags set: the store must win
        run_op(1, 1, 3'b000, 32'h0000_400D, 32'h0000_00A5, 32'h0, 0, 0);
        go_idle();

        // misaligned lw and lh use the aligned word
        run_op(1, 0, 3'b010, 32'h0000_4101, 32'h0, 32'h8765_4321, 0, 0);
        run_op(1, 0, 3'b001, 32'h0000_4103, 32'h0, 32'h8765_4321, 0, 0);
        go_idle();

        for (int i = 0; i < 60; i++) begin
            bit          st, ld, tr;
            int          f3, bs, lat;
            logic [31:0] aw, rd, wd;
            logic [2:0]  f3v;
            st  = bit'($urandom_range(0, 1));
            ld  = st ? bit'($urandom_range(0, 1)) : 1'b1;
            tr  = ($urandom_range(0, 7) == 0);
            lat = $urandom_range(0, 3);
            aw  = 32'h0000_5000 + ($urandom_range(0, 15) << 2);
            if (st) begin
                f3 = $urandom_range(0, 2);
                bs = (f3 == 0) ? $urandom_range(0, 3) : (f3 == 1) ? 2 * $urandom_range(0, 1) : 0;
            end else begin
                case ($urandom_range(0, 4))
                    0: f3 = 0; 1: f3 = 1; 2: f3 = 2; 3: f3 = 4; default: f3 = 5;
                endcase
                bs = $urandom_range(0, 3);
            end
            if (!mem.exists(aw)) mem[aw] = $urandom;
            rd  = st ? $urandom : mem[aw];
            wd  = $urandom;
            f3v = f3[2:0];
            run_op(ld, st, f3v, aw + bs, wd, rd, lat, tr);
            if (tr || $urandom_range(0, 1) == 0) go_idle();
        end
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
